// File: rtl/axi_wr_arbiter.sv
// N-master to 1-slave AXI write-channel arbiter (AW + W), burst-granular.
// Define AXI_WR_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module axi_wr_arbiter #(
    parameter int unsigned M_ID       = 2,
    parameter int unsigned M_WIDTH    = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                              BUS_CLK,
    input  logic                              BUS_RSTN,

    input  logic [(1<<M_WIDTH)-1:0]           M_AWVALID,
    input  logic [(1<<M_WIDTH)*M_ID-1:0]      M_AWID,
    input  logic [(1<<M_WIDTH)*32-1:0]        M_AWADDR,
    input  logic [(1<<M_WIDTH)*8-1:0]         M_AWLEN,
    output logic [(1<<M_WIDTH)-1:0]           M_AWREADY,

    input  logic [(1<<M_WIDTH)-1:0]           M_WVALID,
    input  logic [(1<<M_WIDTH)*DATA_WIDTH-1:0] M_WDATA,
    input  logic [(1<<M_WIDTH)*(DATA_WIDTH/8)-1:0] M_WSTRB,
    input  logic [(1<<M_WIDTH)-1:0]           M_WLAST,
    output logic [(1<<M_WIDTH)-1:0]           M_WREADY,

    output logic                              S_AWVALID,
    output logic [M_ID+M_WIDTH-1:0]           S_AWID,
    output logic [31:0]                       S_AWADDR,
    output logic [7:0]                        S_AWLEN,
    input  logic                              S_AWREADY,

    output logic                              S_WVALID,
    output logic [DATA_WIDTH-1:0]             S_WDATA,
    output logic [DATA_WIDTH/8-1:0]           S_WSTRB,
    output logic                              S_WLAST,
    input  logic                              S_WREADY,

    output logic [M_WIDTH-1:0]                GRANT_IDX,
    output logic                              BUSY
);

    localparam int unsigned N  = 1 << M_WIDTH;
    localparam int unsigned SW = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]         state, state_nxt;
    logic [M_WIDTH-1:0] grant, grant_nxt;
    logic [M_WIDTH-1:0] winner;
    logic               found;

`ifndef AXI_WR_ARB_FIXED_PRIO_EN
    logic [M_WIDTH-1:0] last_grant, last_grant_nxt;
    logic [M_WIDTH-1:0] idx;
`endif

    // Arbitration: pick the winner among current AW requesters
    always_comb begin
        winner = '0;
        found  = 1'b0;
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (M_AWVALID[i]) begin
                winner = M_WIDTH'(i);
                found  = 1'b1;
            end
        end
`else
        idx = '0;
        // scan starts one past the last grant; i = N wraps back onto last_grant
        for (int i = 1; i <= int'(N); i++) begin
            idx = last_grant + M_WIDTH'(i);
            if (!found && M_AWVALID[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
`endif
    end

    // State and grant registers
    always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
        if (!BUS_RSTN) begin
            state <= IDLE;
            grant <= '0;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
            last_grant <= M_WIDTH'(N - 1);
`endif
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
            last_grant <= last_grant_nxt;
`endif
        end
    end

    // Next-state and channel routing
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
        last_grant_nxt = last_grant;
`endif
        M_AWREADY = '0;
        M_WREADY  = '0;
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = winner;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                S_AWVALID        = M_AWVALID[grant];
                M_AWREADY[grant] = S_AWREADY;
                if (M_AWVALID[grant] && S_AWREADY) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                S_WVALID        = M_WVALID[grant];
                M_WREADY[grant] = S_WREADY;
                if (M_WVALID[grant] && S_WREADY && M_WLAST[grant]) begin
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
                    last_grant_nxt = grant;
`endif
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload buses always reflect the granted master; valids gate their use
    assign S_AWID    = {grant, M_AWID[grant*M_ID +: M_ID]};
    assign S_AWADDR  = M_AWADDR[grant*32 +: 32];
    assign S_AWLEN   = M_AWLEN[grant*8 +: 8];
    assign S_WDATA   = M_WDATA[grant*DATA_WIDTH +: DATA_WIDTH];
    assign S_WSTRB   = M_WSTRB[grant*SW +: SW];
    assign S_WLAST   = M_WLAST[grant];

    assign GRANT_IDX = grant;
    assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter (4 masters, 32-bit data).
module tb_axi_wr_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   m_awvalid;
    logic [7:0]   m_awid;
    logic [127:0] m_awaddr;
    logic [31:0]  m_awlen;
    logic [3:0]   m_awready;
    logic [3:0]   m_wvalid;
    logic [127:0] m_wdata;
    logic [15:0]  m_wstrb;
    logic [3:0]   m_wlast;
    logic [3:0]   m_wready;
    logic         s_awvalid;
    logic [3:0]   s_awid;
    logic [31:0]  s_awaddr;
    logic [7:0]   s_awlen;
    logic         s_awready;
    logic         s_wvalid;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic         s_wlast;
    logic         s_wready;
    logic [1:0]   grant_idx;
    logic         busy;

    int total = 0;
    int bad   = 0;

    axi_wr_arbiter #(.M_ID(2), .M_WIDTH(2), .DATA_WIDTH(32)) dut (
        .BUS_CLK(clk), .BUS_RSTN(rst_n),
        .M_AWVALID(m_awvalid), .M_AWID(m_awid), .M_AWADDR(m_awaddr), .M_AWLEN(m_awlen),
        .M_AWREADY(m_awready),
        .M_WVALID(m_wvalid), .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_WLAST(m_wlast),
        .M_WREADY(m_wready),
        .S_AWVALID(s_awvalid), .S_AWID(s_awid), .S_AWADDR(s_awaddr), .S_AWLEN(s_awlen),
        .S_AWREADY(s_awready),
        .S_WVALID(s_wvalid), .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WLAST(s_wlast),
        .S_WREADY(s_wready),
        .GRANT_IDX(grant_idx), .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until the slave AW valid appears, bounded by a cycle budget
    task automatic wait_addr(input int budget);
        int n;
        n = 0;
        #1;
        while (!s_awvalid && n < budget) begin
            step();
            #1;
            n++;
        end
        if (!s_awvalid) check("addr_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int e;
        int beats;

        rst_n     = 1'b0;
        m_awvalid = '0;
        m_wvalid  = '0;
        m_wlast   = '0;
        m_awlen   = '0;
        m_wstrb   = '1;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_awid[2*i +: 2]    = 2'(3 - i);
            m_awaddr[32*i +: 32] = 32'h1000 * 32'(i + 1);
            m_wdata[32*i +: 32]  = 32'hA000_0000 | (32'(i) << 8);
        end

        // reset state
        step();
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant", 64'(grant_idx), 64'(0));
        check("rst_awvalid", 64'(s_awvalid), 64'(0));
        check("rst_wvalid", 64'(s_wvalid), 64'(0));
        check("rst_awready", 64'(m_awready), 64'(0));
        rst_n = 1'b1;
        step();

        // all masters request: single-beat bursts, grants rotate 0,1,2,3,0
        m_awvalid = 4'b1111;
        m_wvalid  = 4'b1111;
        m_wlast   = 4'b1111;
        #1;
        check("idle_awready", 64'(m_awready), 64'(0));
        for (int k = 0; k < 5; k++) begin
            wait_addr(8);
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
            e = 0;
`else
            e = k % 4;
`endif
            check("rr_grant", 64'(grant_idx), 64'(e));
            check("rr_awid_hi", 64'(s_awid[3:2]), 64'(e));
            check("rr_awid_lo", 64'(s_awid[1:0]), 64'(3 - e));
            check("rr_awaddr", 64'(s_awaddr), 64'(32'h1000 * 32'(e + 1)));
            check("rr_awready", 64'(m_awready), 64'(4'b0001 << e));
            check("rr_addr_wready", 64'(m_wready), 64'(0));
            step();
            #1;
            check("rr_wvalid", 64'(s_wvalid), 64'(1));
            check("rr_awvalid_data", 64'(s_awvalid), 64'(0));
            check("rr_wready", 64'(m_wready), 64'(4'b0001 << e));
            check("rr_wdata", 64'(s_wdata), 64'(32'hA000_0000 | (32'(e) << 8)));
            if (k == 4) m_awvalid = '0;
            step();
            #1;
            check("rr_idle_busy", 64'(busy), 64'(0));
            check("rr_idle_wvalid", 64'(s_wvalid), 64'(0));
        end

        // master 2, AWLEN=3: four beats, WLAST on the fourth ends the burst
        m_awvalid = 4'b0100;
        m_awlen[23:16] = 8'd3;
        m_wvalid  = 4'b0100;
        m_wlast   = 4'b0000;
        wait_addr(8);
        check("len_grant", 64'(grant_idx), 64'(2));
        check("len_awlen", 64'(s_awlen), 64'(3));
        step();
        beats = 0;
        for (int b = 0; b < 4; b++) begin
            m_wlast[2] = (b == 3);
            m_wdata[64 +: 32] = 32'hB0 + 32'(b);
            #1;
            check("len_wvalid", 64'(s_wvalid), 64'(1));
            check("len_wdata", 64'(s_wdata), 64'(32'hB0 + 32'(b)));
            check("len_wlast", 64'(s_wlast), 64'(b == 3));
            check("len_wready", 64'(m_wready), 64'(4'b0100));
            if (s_wvalid && s_wready) beats++;
            step();
        end
        #1;
        check("len_beats", 64'(beats), 64'(4));
        check("len_idle_busy", 64'(busy), 64'(0));
        check("len_idle_awready", 64'(m_awready), 64'(0));
        check("len_idle_wvalid", 64'(s_wvalid), 64'(0));
        // pending request re-granted after exactly one idle cycle
        step();
        check("len_busy_again", 64'(busy), 64'(1));
        check("len_grant_again", 64'(grant_idx), 64'(2));

        // AW and W together, slave AW ready held off 3 cycles: W stays blocked
        s_awready = 1'b0;
        m_wlast   = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("early_awvalid", 64'(s_awvalid), 64'(1));
            check("early_awready", 64'(m_awready), 64'(0));
            check("early_wready", 64'(m_wready), 64'(0));
            check("early_wvalid", 64'(s_wvalid), 64'(0));
            step();
        end
        s_awready = 1'b1;
        #1;
        check("early_hs_awready", 64'(m_awready), 64'(4'b0100));
        check("early_hs_wready", 64'(m_wready), 64'(0));
        step();
        #1;
        check("early_data_wready", 64'(m_wready), 64'(4'b0100));
        check("early_data_wvalid", 64'(s_wvalid), 64'(1));
        m_awvalid = '0;
        step();
        #1;
        check("early_idle_busy", 64'(busy), 64'(0));

        // reset during beat 2 of 4 abandons the burst
        m_awvalid = 4'b0010;
        m_awlen[15:8] = 8'd3;
        m_wvalid  = 4'b0010;
        m_wlast   = 4'b0000;
        wait_addr(8);
        check("mid_grant", 64'(grant_idx), 64'(1));
        step();
        #1;
        check("mid_beat1", 64'(s_wvalid), 64'(1));
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_wvalid", 64'(s_wvalid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_grant", 64'(grant_idx), 64'(0));
        check("mid_rst_wready", 64'(m_wready), 64'(0));
        step();
        m_awvalid = 4'b1001;
        rst_n = 1'b1;
        wait_addr(8);
        check("post_rst_grant", 64'(grant_idx), 64'(0));
        check("post_rst_awid_hi", 64'(s_awid[3:2]), 64'(0));

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
        // fixed priority: masters 1 and 3 both asking, master 1 always wins
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        m_awvalid = 4'b1010;
        m_wvalid  = 4'b1010;
        m_wlast   = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            wait_addr(8);
            check("fix_grant", 64'(grant_idx), 64'(1));
            step();
            step();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
